// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - round-robin arbiter sharing one L2 port between I-cache and D-cache miss paths
module l2_mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              r_state;
  logic                r_last_d;
  logic                r_l2_read;
  logic                r_l2_write;
  logic [ADDR_W-1:0]   r_l2_address;
  logic [LINE_W-1:0]   r_l2_wdata;
  logic [CNT_W-1:0]    r_i_cnt;
  logic [CNT_W-1:0]    r_d_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  // On a tie the side that was not served last wins.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & ~w_grant_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b1;
      r_l2_read    <= 1'b0;
      r_l2_write   <= 1'b0;
      r_l2_address <= '0;
      r_l2_wdata   <= '0;
      r_i_cnt      <= '0;
      r_d_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= SERVE_I;
            r_last_d     <= 1'b0;
            r_l2_read    <= 1'b1;
            r_l2_write   <= 1'b0;
            r_l2_address <= i_address;
            r_l2_wdata   <= '0;
            if (r_i_cnt != '1) r_i_cnt <= r_i_cnt + 1'b1;
          end else if (w_grant_d) begin
            // A simultaneous read+write is treated as a write-back.
            r_state      <= SERVE_D;
            r_last_d     <= 1'b1;
            r_l2_read    <= ~d_write;
            r_l2_write   <= d_write;
            r_l2_address <= d_address;
            r_l2_wdata   <= d_wdata;
            if (r_d_cnt != '1) r_d_cnt <= r_d_cnt + 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            r_state      <= IDLE;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_l2_address <= '0;
            r_l2_wdata   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign l2_read     = r_l2_read;
  assign l2_write    = r_l2_write;
  assign l2_address  = r_l2_address;
  assign l2_wdata    = r_l2_wdata;
  assign i_grant_cnt = r_i_cnt;
  assign d_grant_cnt = r_d_cnt;

  assign i_resp  = (r_state == SERVE_I) & l2_resp;
  assign d_resp  = (r_state == SERVE_D) & l2_resp;
  assign i_rdata = i_resp ? l2_rdata : '0;
  assign d_rdata = d_resp ? l2_rdata : '0;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - directed scoreboard bench for l2_mem_arbiter
module tb_l2_mem_arbiter;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic [CNT_W-1:0]  i_grant_cnt;
  logic [CNT_W-1:0]  d_grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit                side_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  l2_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit side_d, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wdata);
    exp_t e;
    e.side_d = side_d; e.wr = wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the next grant, checks it against the scoreboard head, answers after lat cycles.
  task automatic serve(input string tag, input int exp_wait, input int lat,
                       input logic [LINE_W-1:0] rdata, input bit drop);
    int   waits;
    exp_t e;
    waits = 0;
    while (waits < 20 && !(l2_read || l2_write)) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, "_grant_wait"}, waits, exp_wait);
    if (!(l2_read || l2_write)) return;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_l2_read"}, l2_read, !e.wr);
    chk({tag, "_l2_write"}, l2_write, e.wr);
    chk({tag, "_l2_address"}, l2_address, e.addr);
    chk({tag, "_l2_wdata"}, l2_wdata, e.wdata);
    repeat (lat - 1) @(negedge clk);
    chk({tag, "_addr_stable"}, l2_address, e.addr);
    l2_resp = 1'b1;
    l2_rdata = rdata;
    #1;
    if (e.side_d) begin
      chk({tag, "_d_resp"}, d_resp, 1);
      chk({tag, "_d_rdata"}, d_rdata, rdata);
      chk({tag, "_i_resp_idle"}, i_resp, 0);
      if (drop) begin d_read = 0; d_write = 0; end
    end else begin
      chk({tag, "_i_resp"}, i_resp, 1);
      chk({tag, "_i_rdata"}, i_rdata, rdata);
      chk({tag, "_d_resp_idle"}, d_resp, 0);
      if (drop) i_read = 0;
    end
    @(negedge clk);
    l2_resp = 1'b0;
    l2_rdata = '0;
    chk({tag, "_l2_req_cleared"}, l2_read | l2_write, 0);
  endtask

  initial begin
    logic [LINE_W-1:0] a5;
    logic [LINE_W-1:0] ones1;
    logic [LINE_W-1:0] wd;
    a5    = {16{8'hA5}};
    ones1 = {32{4'h1}};
    wd    = {4{32'hDEADBEEF}};

    // Reset state
    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l2_address", l2_address, 0);
    chk("rst_l2_wdata", l2_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_i_cnt", i_grant_cnt, 0);
    chk("rst_d_cnt", d_grant_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single I read
    i_read = 1; i_address = 16'h1230;
    push(0, 0, 16'h1230, '0);
    serve("single_i", 1, 3, a5, 1);
    chk("single_i_cnt", i_grant_cnt, 1);
    chk("single_d_cnt", d_grant_cnt, 0);

    // Simultaneous I read and D write out of reset
    do_reset();
    i_read = 1; i_address = 16'h0040;
    d_write = 1; d_address = 16'h4000; d_wdata = ones1;
    push(0, 0, 16'h0040, '0);
    push(1, 1, 16'h4000, ones1);
    serve("tie_i", 1, 2, a5, 1);
    serve("tie_d", 1, 2, '0, 1);

    // Sustained contention
    do_reset();
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(0, 0, 16'h0100, '0);
      else            push(1, 0, 16'h0200, '0);
    end
    for (int k = 0; k < 6; k++)
      serve($sformatf("rr%0d", k), 1, 1 + (k % 3), {4{k[31:0]}}, k >= 4);
    chk("rr_i_cnt", i_grant_cnt, 3);
    chk("rr_d_cnt", d_grant_cnt, 3);

    // Reset during SERVE_D
    do_reset();
    d_write = 1; d_address = 16'h3000; d_wdata = wd;
    @(negedge clk);
    chk("mid_grant", l2_write, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_l2_write", l2_write, 0);
    chk("mid_l2_read", l2_read, 0);
    chk("mid_l2_address", l2_address, 0);
    chk("mid_l2_wdata", l2_wdata, 0);
    chk("mid_d_cnt", d_grant_cnt, 0);
    d_write = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    l2_resp = 1; l2_rdata = a5;
    #1;
    chk("mid_late_d_resp", d_resp, 0);
    chk("mid_late_d_rdata", d_rdata, 0);
    chk("mid_late_i_resp", i_resp, 0);
    @(negedge clk);
    l2_resp = 0; l2_rdata = '0;
    i_read = 1; i_address = 16'h5550;
    push(0, 0, 16'h5550, '0);
    serve("mid_idle", 1, 1, a5, 1);

    // d_read and d_write together are a write
    do_reset();
    d_read = 1; d_write = 1; d_address = 16'h6000; d_wdata = wd;
    push(1, 1, 16'h6000, wd);
    serve("illegal", 1, 2, '0, 1);

    // Counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin
      i_read = 1; i_address = 16'h0800 + ADDR_W'(k * 16);
      push(0, 0, 16'h0800 + ADDR_W'(k * 16), '0);
      serve($sformatf("sat%0d", k), 1, 1, a5, 1);
      chk($sformatf("sat%0d_cnt", k), i_grant_cnt, (k + 1 > 15) ? 15 : k + 1);
    end
    chk("sat_final", i_grant_cnt, 4'hF);

    // Stray l2_resp in IDLE
    @(negedge clk);
    l2_resp = 1; l2_rdata = a5;
    #1;
    chk("stray_i_resp", i_resp, 0);
    chk("stray_d_resp", d_resp, 0);
    chk("stray_i_rdata", i_rdata, 0);
    chk("stray_d_rdata", d_rdata, 0);
    @(negedge clk);
    l2_resp = 0; l2_rdata = '0;
    chk("stray_l2_req", l2_read | l2_write, 0);
    chk("stray_i_cnt", i_grant_cnt, 4'hF);
    chk("stray_d_cnt", d_grant_cnt, 0);
    d_read = 1; d_address = 16'h7000;
    push(1, 0, 16'h7000, '0);
    serve("stray_after", 1, 1, ones1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Shares the single L2 cache port between the instruction-cache miss path (imem side) and the data-cache miss path (mem side) of the pipelined LC-3b.
- Sits between the two L1 caches and the L2 cache.
- Serialises line requests, alternates grants round-robin, and routes the L2 response back to the owning requester.
- Provides saturating grant counters for performance monitoring.

Parameters:
- LINE_W, 128, cache line width in bits (8 LC-3b words)
- ADDR_W, 16, byte address width
- CNT_W, 16, width of each saturating grant counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request; held high until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held high until d_resp
- d_write  in  1  D-cache line write-back request; held high until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read request to L2
- l2_write  out  1  write request to L2
- l2_address  out  ADDR_W  address to L2
- l2_wdata  out  LINE_W  write data to L2
- l2_rdata  in  LINE_W  read data from L2, valid with l2_resp
- l2_resp  in  1  one-cycle L2 completion pulse
- i_grant_cnt  out  CNT_W  number of I-side grants, saturating
- d_grant_cnt  out  CNT_W  number of D-side grants, saturating

Behaviour:
- Reset (reset_n low, asynchronous) forces the following:
  - state = IDLE, last_grant = D (so the first tie goes to I)
  - l2_read, l2_write, i_resp, d_resp = 0
  - l2_address = 0, l2_wdata = 0
  - both grant counters = 0
- Reset mid-transaction abandons the transaction. No resp is issued. An l2_resp arriving after reset is ignored.
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
- IDLE: evaluate i_req = i_read and d_req = (d_read | d_write).
  - Only one requester active: grant it.
  - Both active: grant the side opposite last_grant.
  - On grant, register the following:
    - address
    - wdata (D only; 0 for I)
    - l2_read/l2_write
    - last_grant
  - On grant, increment that side's counter; the counter holds at all-ones.
  - Move to SERVE_x.
  - Neither active: stay in IDLE with L2 outputs low.
- SERVE_x:
  - l2_read/l2_write/l2_address/l2_wdata hold their registered values, stable until l2_resp.
  - On l2_resp, drive x_resp = 1 combinationally in the same cycle.
  - On l2_resp, x_rdata = l2_rdata in the same cycle.
  - On l2_resp, deassert l2_read/l2_write at the next edge and return to IDLE.
  - The non-owner's resp stays 0 throughout.
- i_rdata/d_rdata:
  - Pass l2_rdata through only while the respective resp is high.
  - Otherwise 0.
- d_read and d_write both high: illegal. The arbiter treats it as a write: l2_write = 1, l2_read = 0.
- Request dropped by its requester while in SERVE_x: the transaction continues to completion. The resp is still pulsed.
- New request arriving while in SERVE_x: not sampled until IDLE.
- l2_resp while in IDLE: ignored, no resp output.
- Latency:
  - Request high at cycle 0 in IDLE gives l2_* valid at cycle 1.
  - l2_resp at cycle N gives x_resp at cycle N and IDLE at N+1.
  - A pending competitor is granted at N+1, with l2_* valid at N+2.
  - Minimum back-to-back spacing is 2 cycles of arbiter overhead.
- Outputs are registered except i_resp/d_resp/i_rdata/d_rdata, which are combinational from l2_resp/l2_rdata gated by state.

Test Plan:
- Single I read: after reset, i_read=1 with i_address=16'h1230; L2 answers on the 3rd cycle after l2_read rises with l2_rdata=128'hA5…A5.
  - Required: l2_read=1, l2_address=16'h1230 at cycle 1.
  - Required: i_resp=1, i_rdata=128'hA5…A5 in the l2_resp cycle; d_resp stays 0.
  - Required: i_grant_cnt=1.
- Simultaneous I and D requests out of reset: i_read=1, d_write=1 (d_address=16'h4000, d_wdata=128'h1111…).
  - Required: I is granted first (last_grant reset = D).
  - Required: D is granted second, with l2_write=1 and l2_wdata=128'h1111…, and l2_address=16'h4000 one cycle after I returns to IDLE.
- Sustained contention, both requesters reasserting immediately after each resp, 6 transactions:
  - Required: grants alternate I,D,I,D,I,D.
  - Required: both counters = 3.
- Reset mid-transaction: assert reset_n=0 during SERVE_D, then pulse l2_resp after release.
  - Required: all outputs 0 immediately on reset.
  - Required: no d_resp; the state returns to IDLE.
- Illegal d_read=d_write=1:
  - Required: l2_write=1, l2_read=0.
- Counter saturation: with CNT_W=4, issue 20 I requests.
  - Required: i_grant_cnt stops at 4'hF.
- Stray l2_resp in IDLE:
  - Required: no resp outputs and no state change.
